// File: rtl/reg_dump_sender_if.sv
// Byte stream handshake between the register dump sender and a downstream transmitter.
interface reg_dump_sender_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_sender.sv
// Snapshots a flattened processor register file on start and streams it out byte by byte,
// register 0 first and most-significant byte first within each register.
module reg_dump_sender #(
    parameter int PROC_BITS = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [PROC_BITS*REG_COUNT-1:0] i_debug_regs,
    reg_dump_sender_if.master              tx,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int BPR = PROC_BITS / 8;
    localparam int N   = REG_COUNT * BPR;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [PROC_BITS*REG_COUNT-1:0] snap_q, snap_d;
    logic                           valid_q, busy_q, done_q;
    logic [7:0]                     bytes_s [N];

    // Next-state, counter and snapshot capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    snap_d  = i_debug_regs;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (valid_q && tx.tx_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; handshake flags are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            snap_q  <= {(PROC_BITS*REG_COUNT){1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            valid_q <= (state_d == S_SEND);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Byte j lives in register j/BPR, counted from that register's top byte.
    for (genvar j = 0; j < N; j++) begin : g_byte
        assign bytes_s[j] = snap_q[(j / BPR) * PROC_BITS + (BPR - 1 - (j % BPR)) * 8 +: 8];
    end

    assign tx.tx_data  = bytes_s[cnt_q];
    assign tx.tx_valid = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_reg_dump_sender.sv
// Randomized scoreboard bench: the driver queues expected bytes, a negedge monitor checks the stream.
module tb_reg_dump_sender;

    localparam int PB  = 32;
    localparam int RC  = 32;
    localparam int BPR = PB / 8;
    localparam int NB  = RC * BPR;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PB*RC-1:0] regs;
    logic            busy, done;
    logic            rdy = 1'b1;
    int              ready_mode = 0;
    int              phase = 0;

    reg_dump_sender_if intf ();
    assign intf.tx_ready = rdy;

    reg_dump_sender #(.PROC_BITS(PB), .REG_COUNT(RC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_debug_regs (regs),
        .tx           (intf.master),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    int xfer_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register r as a number, emitted top byte first.
    task automatic push_dump(input logic [PB*RC-1:0] r_in);
        logic [PB-1:0] r_val;
        for (int r = 0; r < RC; r++) begin
            r_val = r_in[r*PB +: PB];
            for (int b = 0; b < BPR; b++) begin
                exp_q.push_back(8'(r_val >> (8 * (BPR - 1 - b))));
            end
        end
    endtask

    task automatic rand_regs(output logic [PB*RC-1:0] r_out);
        for (int r = 0; r < RC; r++) r_out[r*PB +: PB] = $urandom();
    endtask

    task automatic start_dump(input logic [PB*RC-1:0] r_in);
        @(posedge clk);
        #1;
        regs  = r_in;
        start = 1'b1;
        push_dump(r_in);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("wait_done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("wait_xfer_timeout", 32'(xfer_cnt >= target), 32'd1);
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       rdy = ((phase % 4) == 0) || ((phase % 4) == 3);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
        endcase
        phase++;
    end

    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       done_prev  = 1'b0;
    int         dump_bytes = 0;

    // Monitor: transfers observed mid-cycle occur at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
            dump_bytes = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(intf.tx_valid), 32'd1);
                chk("hold_data", 32'(intf.tx_data), 32'(stall_data));
            end
            if (intf.tx_valid && intf.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", intf.tx_data, $time);
                end else begin
                    chk("byte", 32'(intf.tx_data), 32'(exp_q.pop_front()));
                end
                xfer_cnt++;
                dump_bytes++;
            end
            stall_prev = intf.tx_valid && !intf.tx_ready;
            stall_data = intf.tx_data;
            if (done) begin
                chk("done_byte_count", 32'(dump_bytes), 32'(NB));
                chk("done_single_cycle", 32'(done_prev), 32'd0);
                chk("done_valid_low", 32'(intf.tx_valid), 32'd0);
                chk("done_busy_high", 32'(busy), 32'd1);
                done_cnt++;
                dump_bytes = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        logic [PB*RC-1:0] r;
        int d0, x0, gap, n;
        rst   = 1'b1;
        start = 1'b0;
        regs  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(intf.tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(intf.tx_data), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Ramp pattern with exact latency checks.
        for (int i = 0; i < RC; i++) r[i*PB +: PB] = 32'h0101_0101 * 32'(i);
        ready_mode = 0;
        start_dump(r);
        chk("lat_valid_rise", 32'(intf.tx_valid), 32'd1);
        chk("lat_busy_rise", 32'(busy), 32'd1);
        chk("lat_first_byte", 32'(intf.tx_data), 32'h00);
        repeat (NB - 1) @(posedge clk);
        #1;
        chk("lat_no_early_done", 32'(done), 32'd0);
        chk("lat_last_valid", 32'(intf.tx_valid), 32'd1);
        chk("lat_last_byte", 32'(intf.tx_data), 32'h1F);
        @(posedge clk);
        #1;
        chk("lat_done", 32'(done), 32'd1);
        chk("lat_done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("lat_done_drop", 32'(done), 32'd0);
        chk("lat_idle_busy", 32'(busy), 32'd0);
        chk("ramp_done_count", 32'(done_cnt), 32'd1);

        // DEADBEEF with ready pattern 1,0,0,1.
        rand_regs(r);
        r[PB-1:0] = 32'hDEAD_BEEF;
        ready_mode = 1;
        d0 = done_cnt;
        start_dump(r);
        wait_done(d0 + 1, 2000);

        // Registers change right after start: snapshot must hold.
        rand_regs(r);
        ready_mode = 2;
        d0 = done_cnt;
        start_dump(r);
        regs = '1;
        wait_done(d0 + 1, 2000);

        // Second start mid-dump is ignored.
        rand_regs(r);
        ready_mode = 0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_dump(r);
        wait_xfers(x0 + 50, 500);
        @(posedge clk);
        #1;
        rand_regs(r);
        regs  = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0 + 1, 500);
        repeat (10) @(posedge clk);
        chk("restart_ignored_dones", 32'(done_cnt), 32'(d0 + 1));
        chk("restart_ignored_total", 32'(xfer_cnt - x0), 32'(NB));

        // Asynchronous reset mid-dump.
        rand_regs(r);
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_dump(r);
        wait_xfers(x0 + 10, 500);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(intf.tx_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_data", 32'(intf.tx_data), 32'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt), 32'(d0));
        chk("arst_idle_busy", 32'(busy), 32'd0);
        rand_regs(r);
        start_dump(r);
        chk("arst_restart_byte0", 32'(intf.tx_data), 32'(r[PB-1 -: 8]));
        wait_done(d0 + 1, 500);

        // Start held high: back-to-back dumps with one idle cycle between.
        rand_regs(r);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        regs  = r;
        start = 1'b1;
        push_dump(r);
        push_dump(r);
        gap = 0;
        n   = 0;
        while (n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (done_cnt >= d0 + 2) break;
            if (!busy) gap++;
            else if (gap > 0) start = 1'b0;
        end
        start = 1'b0;
        chk("hold_start_dumps", 32'(done_cnt), 32'(d0 + 2));
        chk("hold_start_gap", 32'(gap), 32'd1);

        repeat (5) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_sender.md
REG_DUMP_SENDER -- requirements
Module: reg_dump_sender

Interface
REQ-001 Parameter PROC_BITS, default 32, width of one processor register in bits; SHALL be a multiple of 8.
REQ-002 Parameter REG_COUNT, default 32, number of registers in the debug snapshot.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  request to snapshot and transmit the register file.
REQ-006 i_debug_regs  input  PROC_BITS*REG_COUNT  flattened register file; register i occupies bits [(i+1)*PROC_BITS-1 : i*PROC_BITS].
REQ-007 o_tx_data  output  8  byte offered to the downstream transmitter.
REQ-008 o_tx_valid  output  1  o_tx_data is valid.
REQ-009 i_tx_ready  input  1  downstream transmitter accepts the offered byte this cycle.
REQ-010 o_busy  output  1  high while a dump is in progress, including the DONE cycle.
REQ-011 o_done  output  1  single-cycle pulse when the last byte has been accepted.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, SEND and DONE.
REQ-013 In IDLE, a rising clock edge with i_start=1 SHALL latch i_debug_regs into an internal snapshot, clear the byte counter to 0, and enter SEND.
REQ-014 After that edge, later changes on i_debug_regs SHALL NOT affect transmitted data until the next accepted start.
REQ-015 Total bytes per dump N = REG_COUNT*PROC_BITS/8 (128 at defaults); the byte counter SHALL be wide enough to hold N-1.
REQ-016 Byte order: register 0 first, ascending register index; within a register, most-significant byte first.
REQ-017 In SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL equal snapshot byte k, where k is the counter value.
REQ-018 A transfer SHALL occur only on a rising edge with o_tx_valid=1 and i_tx_ready=1.
REQ-019 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL hold stable and o_tx_valid SHALL stay 1.
REQ-020 On a transfer with k<N-1, the counter SHALL increment by 1 and the state SHALL remain SEND; back-to-back transfers SHALL sustain one byte per cycle.
REQ-021 On a transfer with k=N-1, the state SHALL go to DONE.
REQ-022 In DONE, o_done=1, o_tx_valid=0 and o_busy=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-023 i_start SHALL be ignored in SEND and DONE; a start held high through DONE SHALL begin a new dump only from IDLE on the following edge.
REQ-024 o_busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-025 Latency: with i_start sampled at edge E and i_tx_ready held at 1, o_tx_valid rises after E, the last byte transfers at edge E+N, and o_done is high during the cycle after edge E+N.
REQ-026 The state machine and the o_done/o_tx_valid decode SHALL be glitch-free registered logic; o_tx_data MAY be a combinational mux of the snapshot and the counter.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, counter=0, o_tx_valid=0, o_busy=0 and o_done=0, regardless of clk.
REQ-028 While rst is asserted, o_tx_data SHALL be 0x00 and the snapshot SHALL be cleared to 0.
REQ-029 rst asserted mid-dump SHALL abort the dump without producing o_done; after release, the block SHALL wait in IDLE for a new i_start.

Verification
REQ-030 Registers i = 0x01010101*i, i_tx_ready=1, pulse i_start -> 128 consecutive bytes 00 00 00 00, 01 01 01 01, ..., 1F 1F 1F 1F; o_done pulses once in the cycle after the 128th transfer.
REQ-031 Register 0 = 0xDEADBEEF, i_tx_ready toggling 1,0,0,1,... -> bytes DE AD BE EF appear in order, each held stable while ready=0, with no duplicates and no drops.
REQ-032 Change i_debug_regs to all-ones one cycle after start -> the transmitted stream still matches the values present at the start edge.
REQ-033 Pulse i_start again at byte 50 -> the stream is unaffected, exactly 128 bytes are sent, and one o_done pulse occurs.
REQ-034 Assert rst asynchronously (between clock edges) at byte 10 -> o_tx_valid and o_busy drop immediately, no o_done occurs; after release, a new i_start restarts from byte 0.
REQ-035 Hold i_start=1 continuously, i_tx_ready=1 -> dumps repeat, separated by the DONE cycle plus one IDLE cycle, with o_busy low for exactly one cycle between dumps.
